serial_add_sub: RTL and testbench
=================================

SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; the legal range is 2..32.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin an operation; sampled only while busy=0.
REQ-005 The module SHALL have port mode, input, 1 bit: 0 = add (a+b), 1 = subtract (a-b); sampled with start.
REQ-006 The module SHALL have ports a and b, input, WIDTH bits each: operands, sampled with start.
REQ-007 The module SHALL have port busy, output, 1 bit: operation in progress.
REQ-008 The module SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 The module SHALL have port sum, output, WIDTH bits: registered result.
REQ-010 The module SHALL have port carryOut, output, 1 bit: final carry out of the MSB.
REQ-011 The module SHALL have port overflow, output, 1 bit: two's-complement signed overflow.
REQ-012 The module SHALL have port zero, output, 1 bit: high when sum == 0.

Function
REQ-013 The module SHALL use two FSM states: IDLE (busy=0) and RUN (busy=1).
REQ-014 In IDLE, start=1 at a rising edge SHALL capture a, b and mode into internal shift registers, load the internal carry with mode, clear the bit counter, and enter RUN.
REQ-015 In RUN, each cycle SHALL process one bit, LSB first, through one full-adder cell: s = a_i ^ b'_i ^ c; c_next = a_i&b'_i | c&(a_i^b'_i), where b' = b for add and ~b for subtract.
REQ-016 After exactly WIDTH RUN cycles, the module SHALL return to IDLE; on that same edge it SHALL update sum, carryOut, overflow and zero together and set done=1 for exactly one cycle.
REQ-017 The latency SHALL be WIDTH cycles from the start-sampling edge to the edge that raises done; busy SHALL be high for exactly WIDTH cycles.
REQ-018 overflow SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-019 In subtract mode, carryOut=1 SHALL mean no borrow (a >= b unsigned).
REQ-020 sum and the flags SHALL hold their last values, unchanged, until the next completion; intermediate bits SHALL NOT appear on sum.
REQ-021 start while busy=1 SHALL be ignored, with no queuing, and the operands SHALL NOT be re-sampled.
REQ-022 start asserted in the done cycle (state IDLE) SHALL be accepted: back-to-back operations run with no idle gap beyond the done cycle.
REQ-023 Results SHALL wrap modulo 2^WIDTH; the carry is reported only via carryOut.

Reset
REQ-024 reset=1 SHALL immediately force: state IDLE, busy=0, done=0, sum=0, carryOut=0, overflow=0, zero=1, and all internal registers and the counter to 0.
REQ-025 reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow, and the outputs SHALL take their reset values.
REQ-026 After reset deasserts, the first start SHALL behave as in REQ-014.

Verification (WIDTH=4 unless noted)
REQ-027 Add with a=0101, b=0100, mode=0 -> after 4 cycles: done pulse, sum=1001, carryOut=0, overflow=1, zero=0.
REQ-028 Add with a=1100, b=0100 -> sum=0000, carryOut=1, overflow=0, zero=1; then subtract with a=0011, b=0101 -> sum=1110, carryOut=0, overflow=0.
REQ-029 start pulsed with a=0001, b=0001, then start again 2 cycles later with a=1111 -> result sum=0010, busy held for 4 cycles, exactly one done pulse.
REQ-030 start held high continuously over two operations (0001+0001, then 0101+0100 presented in the done cycle) -> done pulses 5 cycles apart; sum=0010, then sum=1001.
REQ-031 reset asserted on the 2nd RUN cycle of 0111+0001 -> busy=0 and sum=0000 immediately; no done pulse; a subsequent 0111+0001 -> sum=1000, overflow=1.
REQ-032 WIDTH=8, subtract 0x00 - 0x01 -> after 8 cycles: sum=0xFF, carryOut=0, overflow=0, zero=0.

Source files
------------

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, WIDTH cycles per operation.
// Result and flags are registered together on completion; start is ignored while busy.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut,
    output logic             overflow,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             carry_d;
    logic             bit_s;
    logic             last;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    // b_q holds the already-conditioned operand (~b for subtract), so the cell is a plain adder.
    assign bit_s   = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_d = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    assign res_d   = {bit_s, res_q[WIDTH-1:1]};
    assign last    = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= mode ? ~b : b;
                        carry_q <= mode;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= carry_d;
                    res_q   <= res_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last) begin
                        // carry_q is the carry into the MSB here, carry_d the carry out of it.
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        sum_q   <= res_d;
                        cout_q  <= carry_d;
                        ovf_q   <= carry_q ^ carry_d;
                        zero_q  <= (res_d == '0);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign sum      = sum_q;
    assign carryOut = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed checks of serial_add_sub at WIDTH=4 and WIDTH=8.
module tb_serial_add_sub;
    logic       clk;
    logic       reset;
    logic       start4, mode4;
    logic [3:0] a4, b4;
    logic       busy4, done4, cout4, ovf4, zero4;
    logic [3:0] sum4;
    logic       start8, mode8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8, ovf8, zero8;
    logic [7:0] sum8;

    int n_chk  = 0;
    int n_fail = 0;

    serial_add_sub #(.WIDTH(4)) u4 (
        .clk(clk), .reset(reset), .start(start4), .mode(mode4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .carryOut(cout4),
        .overflow(ovf4), .zero(zero4)
    );

    serial_add_sub #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .start(start8), .mode(mode8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .carryOut(cout8),
        .overflow(ovf8), .zero(zero8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until done4 is seen (bounded); returns the number of edges taken.
    task automatic wait_done4(output int cyc);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            cyc++;
            if (done4) break;
        end
    endtask

    task automatic launch4(input logic m, input logic [3:0] ta, input logic [3:0] tb);
        start4 = 1'b1; mode4 = m; a4 = ta; b4 = tb;
        step();
        start4 = 1'b0;
    endtask

    initial begin
        int cyc;
        int busy_cnt;
        int done_cnt;

        reset = 1'b1;
        start4 = 0; mode4 = 0; a4 = 0; b4 = 0;
        start8 = 0; mode8 = 0; a8 = 0; b8 = 0;
        step();
        step();

        chk("rst_busy", 32'(busy4), 32'd0);
        chk("rst_done", 32'(done4), 32'd0);
        chk("rst_sum", 32'(sum4), 32'd0);
        chk("rst_cout", 32'(cout4), 32'd0);
        chk("rst_ovf", 32'(ovf4), 32'd0);
        chk("rst_zero", 32'(zero4), 32'd1);
        chk("rst_zero8", 32'(zero8), 32'd1);
        reset = 1'b0;
        step();

        // 0101 + 0100 = 1001, signed overflow
        launch4(1'b0, 4'b0101, 4'b0100);
        chk("add1_busy", 32'(busy4), 32'd1);
        wait_done4(cyc);
        chk("add1_lat", 32'(cyc), 32'd4);
        chk("add1_sum", 32'(sum4), 32'b1001);
        chk("add1_cout", 32'(cout4), 32'd0);
        chk("add1_ovf", 32'(ovf4), 32'd1);
        chk("add1_zero", 32'(zero4), 32'd0);
        chk("add1_idle", 32'(busy4), 32'd0);
        step();
        chk("add1_pulse", 32'(done4), 32'd0);
        chk("add1_hold", 32'(sum4), 32'b1001);

        // 1100 + 0100 wraps to zero with carry out
        launch4(1'b0, 4'b1100, 4'b0100);
        wait_done4(cyc);
        chk("add2_sum", 32'(sum4), 32'b0000);
        chk("add2_cout", 32'(cout4), 32'd1);
        chk("add2_ovf", 32'(ovf4), 32'd0);
        chk("add2_zero", 32'(zero4), 32'd1);
        step();

        // 0011 - 0101 = 1110 with borrow
        launch4(1'b1, 4'b0011, 4'b0101);
        wait_done4(cyc);
        chk("sub1_lat", 32'(cyc), 32'd4);
        chk("sub1_sum", 32'(sum4), 32'b1110);
        chk("sub1_cout", 32'(cout4), 32'd0);
        chk("sub1_ovf", 32'(ovf4), 32'd0);
        chk("sub1_zero", 32'(zero4), 32'd0);
        step();

        // start while busy must be ignored
        launch4(1'b0, 4'b0001, 4'b0001);
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy4) busy_cnt++;
            if (done4) done_cnt++;
            if (i == 1) begin start4 = 1'b1; a4 = 4'b1111; end
            if (i == 2) begin
                start4 = 1'b0;
                chk("ign_hold", 32'(sum4), 32'b1110);
            end
            step();
        end
        chk("ign_busy", 32'(busy_cnt), 32'd4);
        chk("ign_done", 32'(done_cnt), 32'd1);
        chk("ign_sum", 32'(sum4), 32'b0010);

        // start held high: second op presented in the done cycle
        launch4(1'b0, 4'b0001, 4'b0001);
        start4 = 1'b1;
        wait_done4(cyc);
        chk("b2b1_lat", 32'(cyc), 32'd4);
        chk("b2b1_sum", 32'(sum4), 32'b0010);
        a4 = 4'b0101; b4 = 4'b0100;
        wait_done4(cyc);
        start4 = 1'b0;
        chk("b2b_gap", 32'(cyc), 32'd5);
        chk("b2b2_sum", 32'(sum4), 32'b1001);
        step();

        // reset during the second RUN cycle aborts the operation
        launch4(1'b0, 4'b0111, 4'b0001);
        step();
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy4), 32'd0);
        chk("abort_sum", 32'(sum4), 32'd0);
        chk("abort_zero", 32'(zero4), 32'd1);
        step();
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done4) done_cnt++;
            step();
        end
        chk("abort_nodone", 32'(done_cnt), 32'd0);
        launch4(1'b0, 4'b0111, 4'b0001);
        wait_done4(cyc);
        chk("post_lat", 32'(cyc), 32'd4);
        chk("post_sum", 32'(sum4), 32'b1000);
        chk("post_ovf", 32'(ovf4), 32'd1);
        chk("post_cout", 32'(cout4), 32'd0);
        step();

        // WIDTH=8: 0x00 - 0x01 = 0xFF with borrow
        start8 = 1'b1; mode8 = 1'b1; a8 = 8'h00; b8 = 8'h01;
        step();
        start8 = 1'b0;
        cyc = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            cyc++;
            if (done8) break;
        end
        chk("w8_lat", 32'(cyc), 32'd8);
        chk("w8_sum", 32'(sum8), 32'hFF);
        chk("w8_cout", 32'(cout8), 32'd0);
        chk("w8_ovf", 32'(ovf8), 32'd0);
        chk("w8_zero", 32'(zero8), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
